// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the parameterised sync FIFO.
package fifo_pkg;
   localparam int DEF_DATA_W    = 4;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_AE_LEVEL  = 2;
   localparam int DEF_AF_MARGIN = 2;

   // Address bits needed to index DEPTH words; pointers carry one extra wrap bit.
   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Default almost_full threshold sits a fixed margin below capacity.
   function automatic int af_default(input int depth);
      return depth - DEF_AF_MARGIN;
   endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// The read register is the FIFO's data_out, so it is reset and holds when idle.
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Storage array; contents are deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   // Read register: loads on an accepted read, otherwise holds its value.
   always_ff @(posedge clk) begin
      if (rst)          rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, occupancy flags and
// registered overflow/underflow pulses for rejected requests.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = af_default(DEPTH),
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [addr_w(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = addr_w(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_acc, rd_acc;

   // Flags come straight from the registered pointers, so they reflect the
   // previous edge's activity; the wrap bit tells full apart from empty.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

   // Acceptance is gated only by the current state, never by the other
   // port: a read when full does not free room for a write that same cycle.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Next-state pointers and rejection pulses.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = wr_en && full;
      unf_d    = rd_en && empty;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // State registers; reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;

   fifo_mem_dp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (data_in),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (data_out)
   );
endmodule
